// File: rtl/exp_stream_pkg.sv
// Shared definitions for the exponent bit streamer: FSM states, the word-store
// read latency and the bit-counter width helper.
package exp_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        FINISH
    } state_t;

    // Cycles from presenting a read address to the word store until its data is usable.
    localparam int RD_LAT = 2;

    // Width of the down-counter that indexes bits within one word.
    function automatic int bit_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/exp_word_ram.sv
// Writable exponent word store: WIDTH x 2**ADDR_WIDTH array with a registered
// read address and a registered read output (two-cycle read latency), synchronous
// write. Plain array so it infers block RAM; contents are never reset.
module exp_word_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q;

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read address register; holds its value between read requests.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            addr_q <= rd_addr;
        end
    end

    // Registered read data, refreshed every cycle from the held address.
    always_ff @(posedge clk) begin
        rd_data <= mem[addr_q];
    end

endmodule

// File: rtl/exp_bit_streamer.sv
// Exponent bit streamer: streams num_words words from a runtime-loadable store,
// most-significant word and bit first, one bit per valid/ready transfer, with a
// prefetch register so word boundaries cost no bubble.
// Optional build macro EXP_SKIP_LZ_EN: leading zero bits of the whole exponent are
// consumed internally so the first streamed bit is the most-significant 1.
module exp_bit_streamer
    import exp_stream_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  bit_valid,
    output logic                  bit_out,
    output logic                  bit_last,
    input  logic                  bit_ready,
    output logic                  done
);

    localparam int BW = bit_cnt_width(WIDTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_W   = CNT_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [BW-1:0]        BIT_TOP   = BW'(WIDTH - 1);
    localparam logic [1:0]           FETCH_END = 2'(RD_LAT - 1);

    state_t state, next_state;

    logic [WIDTH-1:0]      shift_q;
    logic [WIDTH-1:0]      pf_word_q;
    logic [CNT_WIDTH-1:0]  words_left_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [1:0]            pf_pipe_q;
    logic [1:0]            fetch_cnt_q;

    logic [CNT_WIDTH-1:0]  n_clamped;
    logic                  is_final;
    logic                  consume;
    logic                  transfer;
    logic                  advance;
    logic                  issue_pf;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [WIDTH-1:0]      ram_rd_data;

    assign n_clamped = (num_words > DEPTH_W) ? DEPTH_W : num_words;
    assign is_final  = (words_left_q == CNT_WIDTH'(1)) && (bit_cnt_q == '0);

`ifdef EXP_SKIP_LZ_EN
    logic skipping_q;
    assign consume = (state == STREAM) && skipping_q && !shift_q[WIDTH-1] && !is_final;
`else
    assign consume = 1'b0;
`endif

    assign bit_valid = (state == STREAM) && !consume;
    assign bit_out   = bit_valid & shift_q[WIDTH-1];
    assign bit_last  = (state == STREAM) && is_final;
    assign done      = (state == FINISH);
    assign busy      = (state == FETCH) || (state == STREAM);

    assign transfer  = bit_valid && bit_ready;
    assign advance   = transfer || consume;
    assign issue_pf  = advance && (bit_cnt_q == BIT_TOP) && (words_left_q > CNT_WIDTH'(1));

    exp_word_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // State register; reset aborts any stream in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus word-store read requests (first word on start, next word on prefetch).
    always_comb begin
        next_state  = state;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_clamped != '0) begin
                        next_state  = FETCH;
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = ADDR_WIDTH'(n_clamped - CNT_WIDTH'(1));
                    end else begin
                        next_state = FINISH;
                    end
                end
            end
            FETCH: begin
                if (fetch_cnt_q == FETCH_END) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (transfer && is_final) begin
                    next_state = FINISH;
                end
                if (issue_pf) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = ADDR_WIDTH'(words_left_q - CNT_WIDTH'(2));
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: length capture, fetch wait, shift register, counters and prefetch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            pf_word_q    <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            pf_pipe_q    <= '0;
            fetch_cnt_q  <= '0;
`ifdef EXP_SKIP_LZ_EN
            skipping_q   <= 1'b0;
`endif
        end else begin
            pf_pipe_q <= {pf_pipe_q[0], issue_pf};
            if (pf_pipe_q[1]) begin
                pf_word_q <= ram_rd_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        words_left_q <= n_clamped;
                        bit_cnt_q    <= BIT_TOP;
                        fetch_cnt_q  <= '0;
                    end
                end
                FETCH: begin
                    fetch_cnt_q <= fetch_cnt_q + 2'd1;
                    if (fetch_cnt_q == FETCH_END) begin
                        shift_q <= ram_rd_data;
`ifdef EXP_SKIP_LZ_EN
                        skipping_q <= 1'b1;
`endif
                    end
                end
                STREAM: begin
                    if (advance) begin
                        if (bit_cnt_q == '0) begin
                            bit_cnt_q    <= BIT_TOP;
                            words_left_q <= words_left_q - CNT_WIDTH'(1);
                            shift_q      <= pf_word_q;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - BW'(1);
                            shift_q   <= shift_q << 1;
                        end
                    end
`ifdef EXP_SKIP_LZ_EN
                    if (transfer) begin
                        skipping_q <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_bit_streamer.sv
// Self-checking bench for exp_bit_streamer (WIDTH=8, ADDR_WIDTH=2). Expected bit
// sequences come from a word-array model flattened MSB-first into a queue.
module tb_exp_bit_streamer;

    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [CW-1:0] num_words;
    logic          busy;
    logic          bit_valid;
    logic          bit_out;
    logic          bit_last;
    logic          bit_ready;
    logic          done;

    logic [W-1:0]  model_mem [DEPTH];
    int            checks;
    int            errors;

    exp_bit_streamer #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .bit_ready (bit_ready),
        .done      (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic write_word(input int addr, input logic [W-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        model_mem[addr] = data;
    endtask

    // ready_mode: 0 = always high, 1 = toggling, 2 = random. abort_after >= 0 resets after that many transfers.
    task automatic applyStimulus(input int n, input int ready_mode, input int abort_after);
        bit   exp_q[$];
        int   nc, lz, idx, cyc, first_cyc, last_cyc, done_cyc;
        logic held, held_bit, r;
        nc = (n > DEPTH) ? DEPTH : n;
        exp_q.delete();
        for (int w = nc - 1; w >= 0; w--)
            for (int b = W - 1; b >= 0; b--)
                exp_q.push_back(model_mem[w][b]);
        lz = 0;
`ifdef EXP_SKIP_LZ_EN
        while (exp_q.size() > 1 && exp_q[0] == 1'b0) begin
            void'(exp_q.pop_front());
            lz++;
        end
`endif
        @(negedge clk);
        start     = 1'b1;
        num_words = CW'(n);
        bit_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 1; first_cyc = -1; last_cyc = -1; done_cyc = -1; held = 1'b0; held_bit = 1'b0;
        while (cyc < 300) begin
            if (cyc == 1) checkOutput("busy_after_start", busy, nc != 0);
            if (held) begin
                checkOutput("hold_valid", bit_valid, 1'b1);
                checkOutput("hold_bit", bit_out, held_bit);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            wr_en   = (cyc == 2) && (nc > 0);
            wr_addr = '0;
            wr_data = ~model_mem[0];
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            bit_ready = r;
            held = 1'b0;
            if (bit_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (r) begin
                    if (idx < exp_q.size()) begin
                        checkOutput($sformatf("bit%0d", idx), bit_out, exp_q[idx]);
                        checkOutput($sformatf("last%0d", idx), bit_last, idx == exp_q.size() - 1);
                    end else begin
                        checkOutput("extra_transfer", idx + 1, exp_q.size());
                    end
                    idx++;
                    last_cyc = cyc;
                end else begin
                    held     = 1'b1;
                    held_bit = bit_out;
                end
            end
            @(posedge clk);
            if (abort_after >= 0 && idx == abort_after) break;
            @(negedge clk);
            cyc++;
        end
        wr_en     = 1'b0;
        bit_ready = 1'b0;
        if (abort_after >= 0) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_valid", bit_valid, 1'b0);
            checkOutput("rst_bit", bit_out, 1'b0);
            checkOutput("rst_last", bit_last, 1'b0);
            checkOutput("rst_done", done, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                checkOutput("no_done_after_abort", done, 1'b0);
                checkOutput("idle_after_abort", bit_valid, 1'b0);
            end
            return;
        end
        checkOutput("done_seen", done_cyc > 0, 1'b1);
        checkOutput("transfer_count", idx, exp_q.size());
        if (nc == 0) begin
            checkOutput("zero_done_cycle", done_cyc, 1);
        end else begin
            checkOutput("first_valid_cycle", first_cyc, 3 + lz);
            checkOutput("done_after_last", done_cyc, last_cyc + 1);
            checkOutput("busy_at_done", busy, 1'b0);
            if (ready_mode == 0) checkOutput("no_bubble", last_cyc - first_cyc, exp_q.size() - 1);
        end
        @(negedge clk);
        checkOutput("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        num_words = '0;
        bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_valid", bit_valid, 1'b0);
        checkOutput("reset_bit", bit_out, 1'b0);
        checkOutput("reset_last", bit_last, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        reset = 1'b0;

        write_word(0, 8'h3C);
        write_word(1, 8'hA5);
        write_word(2, 8'h00);
        write_word(3, 8'h81);

        applyStimulus(2, 0, -1);
        applyStimulus(2, 1, -1);
        applyStimulus(0, 0, -1);
        applyStimulus(7, 0, -1);
        applyStimulus(4, 0, 5);
        applyStimulus(4, 0, -1);

        write_word(1, 8'h00);
        write_word(0, 8'h05);
        applyStimulus(2, 0, -1);
        write_word(0, 8'h00);
        applyStimulus(2, 1, -1);

        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_word(a, ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom));
            end
            applyStimulus(int'($urandom_range(0, 7)), 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_bit_streamer.md
Name: exp_bit_streamer

Overview:
Parametrised successor to the single-port exponent ROM wrappers. It holds a writable exponent word store. On start it streams num_words words out one bit per transfer, most-significant word and bit first, over a valid/ready handshake, to feed the square-and-multiply controller. It replaces a fixed .mif ROM with a runtime-loadable store, a variable exponent length and a bubble-free prefetch.

Parameters:
WIDTH, 32, exponent word width in bits (>= 4)
ADDR_WIDTH, 7, word address width; DEPTH = 2**ADDR_WIDTH words
CNT_WIDTH, ADDR_WIDTH+1, width of num_words

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe into the word store
wr_addr  input  ADDR_WIDTH  write word address
wr_data  input  WIDTH  write data
start  input  1  begin streaming; sampled only in IDLE
num_words  input  CNT_WIDTH  words to stream; captured on start
busy  output  1  high from the cycle after start until done
bit_valid  output  1  bit_out is valid
bit_out  output  1  current exponent bit
bit_last  output  1  qualifies the final bit (valid with bit_valid)
bit_ready  input  1  consumer accepts the bit
done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset: busy, bit_valid, bit_out, bit_last and done are 0; state is IDLE. Word-store contents are not reset.
- Reset asserted mid-stream aborts immediately. No done pulse is issued.
- Word store:
  - Registered read address and registered read data, giving a 2-cycle read latency.
  - Synchronous write.
  - wr_en is honoured only in IDLE; it is ignored while busy.
  - Read-during-write to the same address cannot occur, because writes are IDLE-only.
- Word order: address num_words-1 is the most significant word, streamed down to address 0. Within a word, bit WIDTH-1 goes first.
- num_words capture:
  - Clamped to DEPTH.
  - num_words==0: no bits are streamed; done pulses 1 cycle after start; busy stays 0.
- FSM states: IDLE, FETCH, STREAM, FINISH.
  - IDLE -> FETCH on start with num_words != 0. The read address is set to num_words-1.
  - FETCH: waits 2 cycles for the read data, loads the shift register, then goes to STREAM. The first bit_valid appears in the 3rd cycle after the start edge.
  - STREAM: a transfer occurs when bit_valid && bit_ready. The shift register shifts left by 1 on each transfer.
  - Prefetch: the next word address is issued when the first bit of the current word transfers. The next word is held in a prefetch register. After the last bit of the current word, the next word loads with no bubble.
  - bit_valid and bit_out hold stable while bit_ready is low.
  - bit_last is high exactly on the final bit (word 0, bit 0).
  - The transfer of the last bit moves the FSM to FINISH. FINISH pulses done and returns to IDLE.
- start while busy is ignored.
- Counters:
  - Word counter: CNT_WIDTH bits, decrements.
  - Bit counter: $clog2(WIDTH) bits, wraps to WIDTH-1 at each word boundary.

Optional Feature:
Macro: EXP_SKIP_LZ_EN.
- Defined: leading zero bits of the whole exponent are consumed internally, one bit per cycle, with bit_valid held low. The first streamed bit is the most-significant 1. An all-zero exponent streams a single 0 bit with bit_last=1.
- Undefined: exactly num_words*WIDTH bits are streamed, zeros included.

Decomposition:
- Package exp_stream_pkg holds:
  - the FSM state enum (IDLE, FETCH, STREAM, FINISH);
  - the read-latency constant RD_LAT=2;
  - a clog2-based bit-counter width function.
- One sub-module: exp_word_ram. It is a parametrised WIDTH x DEPTH array with registered address and registered output, and is inferred with no vendor primitive.

Test Plan:
- WIDTH=8, ADDR_WIDTH=2. Write 0xA5 at addr 1 and 0x3C at addr 0. Start with num_words=2 and bit_ready tied high.
  -> bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 consecutive cycles (no bubble at the word boundary). bit_last is high on the 16th bit. done pulses on the following cycle. The first bit_valid is 3 cycles after start.
- Same data, bit_ready toggling 1,0,1,0.
  -> each bit held stable while ready is low. Exactly 16 transfers in the same order.
- num_words=0.
  -> no bit_valid; done pulses 1 cycle after start.
- num_words=7 with DEPTH=4.
  -> clamped: 32 bits streamed from addr 3 down to 0.
- Assert reset after 5 transfers, then start again.
  -> outputs are 0 during reset and no done pulse is issued. The restart streams from the first bit again, with store contents intact. wr_en while busy leaves memory unchanged.
- EXP_SKIP_LZ_EN defined, words {0x00,0x05}.
  -> streams 1,0,1 with bit_last on the final 1. With words {0x00,0x00}, a single 0 bit with bit_last=1.
